// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions for the L2 cache and its backing store:
// default geometry, the block type and the responder state encoding.
package mem_if_pkg;

  localparam int PKG_DATA_WIDTH  = 8;
  localparam int PKG_ADDR_WIDTH  = 4;
  localparam int PKG_BLOCK_SIZE  = 4;
  localparam int PKG_OFFSET_BITS = $clog2(PKG_BLOCK_SIZE);

  typedef logic [PKG_BLOCK_SIZE-1:0][PKG_DATA_WIDTH-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_block_array.sv
// Block-wide storage for the backing memory: one synchronous write port and
// one synchronous read port. Contents survive reset.
module mem_block_array
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int BLOCK_SIZE = PKG_BLOCK_SIZE,
  parameter int IDX_W      = PKG_ADDR_WIDTH - PKG_OFFSET_BITS
) (
  input  logic                                  clk,
  input  logic                                  wr_en,
  input  logic [IDX_W-1:0]                      wr_idx,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic                                  rd_en,
  input  logic [IDX_W-1:0]                      rd_idx,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rd_data
);

  localparam int NUM_BLOCKS = 2 ** IDX_W;

  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem [NUM_BLOCKS];

  // Write a whole block when the responder performs a write access.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Capture a whole block on a read access; hold it otherwise.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/main_memory_resp.sv
// Backing-store responder below the L2: accepts one block read or write at a
// time, answers after LATENCY edges with a one-cycle mem_ready pulse, and waits
// for the request to be released before accepting the next one.
module main_memory_resp
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int ADDR_WIDTH = PKG_ADDR_WIDTH,
  parameter int BLOCK_SIZE = PKG_BLOCK_SIZE,
  parameter int LATENCY    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
  output logic                                  mem_ready,
  output logic                                  protocol_err,
  output logic [15:0]                           rd_count,
  output logic [15:0]                           wr_count
);

  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int IDX_W       = ADDR_WIDTH - OFFSET_BITS;
  localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  mem_state_t                            state;
  logic [CNT_W-1:0]                      cnt;
  logic [IDX_W-1:0]                      req_idx;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_data;
  logic                                  req_write;
  logic                                  data_valid;
  logic                                  access;
  logic                                  accept;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rd_data;
  logic                                  unused_offset_bits;

  // Word-offset bits never select anything: requests are block granular.
  assign unused_offset_bits = ^mem_addr[OFFSET_BITS-1:0];

  assign accept = (state == IDLE) && (mem_read || mem_write);

  // The access edge is gated by rst_n so a reset aborts the pending write.
  assign access = rst_n && (state == BUSY) && (cnt == '0);

  // Read data reads as zero from reset until the first completed read.
  assign mem_data_block = data_valid ? rd_data : '0;

  // Snapshot the request at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_idx   <= mem_addr[ADDR_WIDTH-1:OFFSET_BITS];
      req_data  <= mem_data_in;
      req_write <= mem_write;
    end
  end

  // Request sequencing, latency countdown, completion pulse and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_ready    <= 1'b0;
      protocol_err <= 1'b0;
      rd_count     <= 16'd0;
      wr_count     <= 16'd0;
      data_valid   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CNT_W'(LATENCY - 1);
            state <= BUSY;
            if (mem_read && mem_write) begin
              protocol_err <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            mem_ready <= 1'b1;
            state     <= RESP;
            if (!req_write) begin
              data_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (req_write) begin
            wr_count <= sat_inc(wr_count);
          end else begin
            rd_count <= sat_inc(rd_count);
          end
          state <= DONE;
        end
        DONE: begin
          // A request still held from the last transaction must not be re-served.
          if (!mem_read && !mem_write) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_block_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (access && req_write),
    .wr_idx  (req_idx),
    .wr_data (req_data),
    .rd_en   (access && !req_write),
    .rd_idx  (req_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_main_memory_resp.sv
// Bench for main_memory_resp: one instance at LATENCY=3 and one at LATENCY=1,
// a transaction-level reference model, a per-cycle compare process, directed
// scenarios with literal expectations and a randomized traffic phase.
module tb_main_memory_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic [3:0]  mem_addr    [2];
  logic [31:0] mem_data_in [2];
  wire  [31:0] dout [2];
  wire  [1:0]  ready;
  wire  [1:0]  perr;
  wire  [15:0] rdc [2];
  wire  [15:0] wrc [2];

  int vectors = 0;
  int miscompares = 0;

  main_memory_resp #(.LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n[0]), .mem_addr(mem_addr[0]), .mem_data_in(mem_data_in[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_data_block(dout[0]),
    .mem_ready(ready[0]), .protocol_err(perr[0]), .rd_count(rdc[0]), .wr_count(wrc[0])
  );

  main_memory_resp #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n[1]), .mem_addr(mem_addr[1]), .mem_data_in(mem_data_in[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_data_block(dout[1]),
    .mem_ready(ready[1]), .protocol_err(perr[1]), .rd_count(rdc[1]), .wr_count(wrc[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  bit          m_active [2];
  int          m_left   [2];   // edges until the access happens, 0 = none pending
  bit          m_resp   [2];   // completion pulse is showing this cycle
  bit          m_wait   [2];   // completed; waiting for the request to be released
  bit          m_opw    [2];
  logic [1:0]  m_idx    [2];
  logic [31:0] m_data   [2];
  logic [31:0] m_mem    [2][4];
  bit          m_known  [2][4];
  bit          e_ready  [2];
  bit          e_err    [2];
  bit          e_dknown [2];
  logic [31:0] e_data   [2];
  int          e_rd     [2];
  int          e_wr     [2];

  task automatic model_step(input int d);
    if (!rst_n[d]) begin
      m_active[d] = 1'b1;
      m_left[d] = 0; m_resp[d] = 1'b0; m_wait[d] = 1'b0;
      e_ready[d] = 1'b0; e_err[d] = 1'b0; e_data[d] = '0; e_dknown[d] = 1'b1;
      e_rd[d] = 0; e_wr[d] = 0;
    end else if (m_active[d]) begin
      e_ready[d] = 1'b0;
      if (m_resp[d]) begin
        m_resp[d] = 1'b0;
        if (m_opw[d]) begin
          if (e_wr[d] < 65535) e_wr[d]++;
        end else begin
          if (e_rd[d] < 65535) e_rd[d]++;
        end
        m_wait[d] = 1'b1;
      end else if (m_wait[d]) begin
        if (!mem_read[d] && !mem_write[d]) m_wait[d] = 1'b0;
      end else if (m_left[d] > 0) begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          if (m_opw[d]) begin
            m_mem[d][m_idx[d]] = m_data[d];
            m_known[d][m_idx[d]] = 1'b1;
          end else begin
            e_data[d] = m_mem[d][m_idx[d]];
            e_dknown[d] = m_known[d][m_idx[d]];
          end
          e_ready[d] = 1'b1;
          m_resp[d] = 1'b1;
        end
      end else if (mem_read[d] || mem_write[d]) begin
        m_idx[d] = mem_addr[d][3:2];
        m_opw[d] = mem_write[d];
        m_data[d] = mem_data_in[d];
        m_left[d] = lat_of(d);
        if (mem_read[d] && mem_write[d]) e_err[d] = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (m_active[d]) begin
        chk($sformatf("dut%0d mem_ready", d), 64'(ready[d]), 64'(e_ready[d]));
        chk($sformatf("dut%0d protocol_err", d), 64'(perr[d]), 64'(e_err[d]));
        chk($sformatf("dut%0d rd_count", d), 64'(rdc[d]), 64'(e_rd[d]));
        chk($sformatf("dut%0d wr_count", d), 64'(wrc[d]), 64'(e_wr[d]));
        if (e_dknown[d]) chk($sformatf("dut%0d mem_data_block", d), 64'(dout[d]), 64'(e_data[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Issues one request at the current negedge, waits (bounded) for mem_ready,
  // holds it 'extra' more cycles, then releases it for one cycle.
  task automatic do_req(input int d, input bit rd, input bit wr, input logic [3:0] a,
                        input logic [31:0] data, input int extra,
                        output int lat, output logic [31:0] got, output int extra_pulses);
    mem_addr[d] = a; mem_data_in[d] = data; mem_read[d] = rd; mem_write[d] = wr;
    lat = 0; got = '0; extra_pulses = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready[d] && lat < 30);
    got = dout[d];
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      if (ready[d]) extra_pulses++;
    end
    mem_read[d] = 1'b0; mem_write[d] = 1'b0;
    mem_addr[d] = 4'($urandom); mem_data_in[d] = $urandom;
    @(negedge clk);
    if (ready[d]) extra_pulses++;
  endtask

  initial begin
    int lat, pulses;
    logic [31:0] got;
    int st [2];
    int cnt [2];
    int r;

    rst_n = 2'b00; mem_read = 2'b00; mem_write = 2'b00;
    for (int d = 0; d < 2; d++) begin
      mem_addr[d] = '0; mem_data_in[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 2'b11;

    // idle after reset
    repeat (5) begin
      @(negedge clk);
      chk("idle mem_ready", 64'(ready[0]), 64'd0);
      chk("idle protocol_err", 64'(perr[0]), 64'd0);
      chk("idle rd_count", 64'(rdc[0]), 64'd0);
      chk("idle wr_count", 64'(wrc[0]), 64'd0);
    end

    // LATENCY=3 write then aliased read
    do_req(0, 1'b0, 1'b1, 4'hA, 32'hFFFF_FFFF, 1, lat, got, pulses);
    chk("wr A latency", 64'(lat), 64'd4);
    chk("wr A single pulse", 64'(pulses), 64'd0);
    chk("wr A wr_count", 64'(wrc[0]), 64'd1);
    do_req(0, 1'b1, 1'b0, 4'hB, 32'h0, 2, lat, got, pulses);
    chk("rd B latency", 64'(lat), 64'd4);
    chk("rd B data", 64'(got), 64'hFFFF_FFFF);
    chk("rd B held no repulse", 64'(pulses), 64'd0);
    chk("rd B rd_count", 64'(rdc[0]), 64'd1);

    // read and write together: write wins, error sticks
    do_req(0, 1'b1, 1'b1, 4'h4, 32'hCCCC_CCCC, 1, lat, got, pulses);
    chk("both protocol_err", 64'(perr[0]), 64'd1);
    chk("both rd_count", 64'(rdc[0]), 64'd1);
    chk("both wr_count", 64'(wrc[0]), 64'd2);
    do_req(0, 1'b1, 1'b0, 4'h4, 32'h0, 1, lat, got, pulses);
    chk("rd 4 data", 64'(got), 64'hCCCC_CCCC);
    chk("rd 4 rd_count", 64'(rdc[0]), 64'd2);
    chk("rd 4 protocol_err sticky", 64'(perr[0]), 64'd1);

    // reset in the middle of a write aborts it
    do_req(0, 1'b0, 1'b1, 4'h0, 32'h2222_2222, 1, lat, got, pulses);
    mem_addr[0] = 4'h0; mem_data_in[0] = 32'h1111_1111; mem_write[0] = 1'b1;
    @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1; mem_write[0] = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready[0]) pulses++;
    end
    chk("abort no mem_ready", 64'(pulses), 64'd0);
    chk("abort wr_count", 64'(wrc[0]), 64'd0);
    do_req(0, 1'b1, 1'b0, 4'h0, 32'h0, 1, lat, got, pulses);
    chk("rd 0 after abort data", 64'(got), 64'h2222_2222);
    chk("rd 0 after abort rd_count", 64'(rdc[0]), 64'd1);

    // LATENCY=1 back-to-back
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b0, 1'b1, 4'(i * 4 + 1), 32'h0101_0101 * (i + 1), 1, lat, got, pulses);
      chk($sformatf("l1 wr %0d latency", i), 64'(lat), 64'd2);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b1, 1'b0, 4'(i * 4 + 2), 32'h0, 1, lat, got, pulses);
      chk($sformatf("l1 rd %0d latency", i), 64'(lat), 64'd2);
      chk($sformatf("l1 rd %0d data", i), 64'(got), 64'(32'h0101_0101 * (i + 1)));
    end
    chk("l1 wr_count", 64'(wrc[1]), 64'd4);
    chk("l1 rd_count", 64'(rdc[1]), 64'd4);

    // randomized traffic on both instances
    st = '{0, 0};
    cnt = '{0, 0};
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        case (st[d])
          0: begin
            if ($urandom_range(3) == 0) begin
              r = $urandom_range(9);
              mem_read[d]  = (r <= 4);
              mem_write[d] = (r == 0) || (r >= 5);
              mem_addr[d]  = 4'($urandom);
              mem_data_in[d] = $urandom;
              cnt[d] = 0;
              st[d] = 1;
            end
          end
          1: begin
            cnt[d]++;
            mem_addr[d] = 4'($urandom);
            mem_data_in[d] = $urandom;
            if (ready[d]) begin
              cnt[d] = $urandom_range(1, 3);
              st[d] = 2;
            end else if (cnt[d] > 20) begin
              chk($sformatf("dut%0d random request timeout", d), 64'd1, 64'd0);
              mem_read[d] = 1'b0; mem_write[d] = 1'b0;
              cnt[d] = 2;
              st[d] = 3;
            end
          end
          2: begin
            cnt[d]--;
            if (cnt[d] == 0) begin
              mem_read[d] = 1'b0; mem_write[d] = 1'b0;
              cnt[d] = 1;
              st[d] = 3;
            end
          end
          default: begin
            cnt[d]--;
            if (cnt[d] <= 0) st[d] = 0;
          end
        endcase
      end
    end
    mem_read = 2'b00; mem_write = 2'b00;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
